// File: rtl/router_pkg.sv
// Shared constants and helpers for the mesh router switch.
package router_pkg;

  localparam int LOCAL = 0;
  localparam int EAST  = 1;
  localparam int WEST  = 2;
  localparam int NORTH = 3;
  localparam int SOUTH = 4;

  // Ceiling log2, never below 1 so a field always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/router_switch_if.sv
// Flit-level handshake bundle between the router switch and its neighbours.
interface router_switch_if #(
  parameter int NPORTS = 5,
  parameter int DW     = 8
);
  logic [NPORTS*DW-1:0] in_data;
  logic [NPORTS-1:0]    in_valid;
  logic [NPORTS-1:0]    in_ready;
  logic [NPORTS*DW-1:0] out_data;
  logic [NPORTS-1:0]    out_valid;
  logic [NPORTS-1:0]    out_ready;
  logic [15:0]          drop_cnt;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_cnt
  );
endinterface

// File: rtl/router_switch_arb.sv
// Round-robin arbiter: one-hot grant, pointer holds the last granted requester.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int PTRW = clog2(N);

  logic [PTRW-1:0] ptr_q, ptr_d;

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    int              cand;
    logic [PTRW-1:0] ci;
    logic            found;
    cand  = 0;
    ci    = '0;
    found = 1'b0;
    gnt   = '0;
    ptr_d = ptr_q;
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      ci = PTRW'(cand);
      if (en && !found && req[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        ptr_d   = ci;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PTRW'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/router_switch.sv
// NPORTS x NPORTS flit switch: per-input FIFO, per-output round-robin arbiter
// and registered output stage; flits with an out-of-range destination are dropped.
module router_switch
  import router_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int DW     = 8,
  parameter int DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  router_switch_if.slave bus
);
  localparam int PW = clog2(NPORTS);
  localparam int AW = clog2(DEPTH);

  logic [DW-1:0]                 mem_q [NPORTS][DEPTH];
  logic [DW-1:0]                 mem_d [NPORTS][DEPTH];
  logic [NPORTS-1:0][AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NPORTS-1:0][DW-1:0]     head, out_data_q, out_data_d;
  logic [NPORTS-1:0][PW-1:0]     dest;
  logic [NPORTS-1:0]             empty, full, push, pop, bad, drop, loadable;
  logic [NPORTS-1:0]             out_valid_q, out_valid_d;
  logic [NPORTS-1:0][NPORTS-1:0] req, gnt;   // [output][input]
  logic [15:0]                   drop_cnt_q, drop_cnt_d;
  logic [16:0]                   drop_sum;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    assign empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
    assign full[p]  = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                      (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
    assign push[p]  = bus.in_valid[p] && !full[p];
    assign head[p]  = mem_q[p][rd_ptr_q[p][AW-1:0]];
    assign dest[p]  = head[p][DW-1 -: PW];
    assign bad[p]   = (32'(dest[p]) >= 32'(NPORTS));
    assign drop[p]  = !empty[p] && bad[p];
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    for (genvar p = 0; p < NPORTS; p++) begin : g_req
      assign req[o][p] = !empty[p] && !bad[p] && (dest[p] == PW'(o));
    end
    assign loadable[o] = !out_valid_q[o] || bus.out_ready[o];

    rr_arbiter #(.N(NPORTS)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (req[o]),
      .en  (loadable[o]),
      .gnt (gnt[o])
    );
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pop         = '0;
    drop_sum    = {1'b0, drop_cnt_q};

    for (int p = 0; p < NPORTS; p++) begin
      if (push[p]) begin
        mem_d[p][wr_ptr_q[p][AW-1:0]] = bus.in_data[p*DW +: DW];
        wr_ptr_d[p] = wr_ptr_q[p] + (AW+1)'(1);
      end
    end

    // A loadable output with no winner empties; a stalled one holds.
    for (int o = 0; o < NPORTS; o++) begin
      if (|gnt[o])          out_valid_d[o] = 1'b1;
      else if (loadable[o]) out_valid_d[o] = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
        if (gnt[o][p]) begin
          out_data_d[o] = head[p];
          pop[p]        = 1'b1;
        end
      end
    end

    for (int p = 0; p < NPORTS; p++) begin
      if (drop[p]) pop[p] = 1'b1;
      if (pop[p])  rd_ptr_d[p] = rd_ptr_q[p] + (AW+1)'(1);
      drop_sum = drop_sum + 17'(drop[p]);
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage needs no reset: pointers alone define what is buffered.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = ~full;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: doc/router_switch.md
ROUTER_SWITCH -- requirements
Module: router_switch

Interface
REQ-001 SHALL have parameter NPORTS, default 5, port count (2..8; index 0 = local, 1 = east, 2 = west, 3 = north, 4 = south).
REQ-002 SHALL have parameter DW, default 8, flit width in bits (PW+1..64).
REQ-003 SHALL have parameter DEPTH, default 4, per-input FIFO depth (power of 2, >= 2).
REQ-004 SHALL derive PW = clog2(NPORTS), the destination field width, from flit bits [DW-1 -: PW].
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_data  input  NPORTS*DW  flit per input; port p occupies bits [p*DW +: DW].
REQ-009 in_valid  input  NPORTS  flit present per input.
REQ-010 in_ready  output  NPORTS  input FIFO not full.
REQ-011 out_data  output  NPORTS*DW  registered flit per output, same packing as in_data.
REQ-012 out_valid  output  NPORTS  registered output flit valid.
REQ-013 out_ready  input  NPORTS  downstream accepts output flit.
REQ-014 drop_cnt  output  16  saturating count of dropped flits.

Function
REQ-015 Input p SHALL accept a flit on an edge where in_valid[p] && in_ready[p].
REQ-016 in_ready[p] SHALL equal !full[p] only; no push while full, even if a pop occurs in the same cycle.
REQ-017 Each non-empty FIFO SHALL request exactly one output: the one indexed by its head flit's destination field.
REQ-018 A head flit with destination >= NPORTS SHALL be popped without output within one cycle of reaching the head, and drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-019 Each output SHALL have a round-robin arbiter; after granting input g, priority order SHALL be g+1, g+2, ... wrapping modulo NPORTS.
REQ-020 An arbiter pointer SHALL advance only on an actual grant; with no requests it SHALL hold.
REQ-021 Output o SHALL be loadable when !out_valid[o] || out_ready[o]; a grant SHALL occur only when output o is loadable.
REQ-022 On grant, the winning FIFO SHALL pop and the head flit SHALL be written to out_data[o], with out_valid[o] set on the same edge.
REQ-023 When output o is loadable and has no grant, out_valid[o] SHALL clear on the edge where out_ready[o] is high; out_data[o] SHALL hold.
REQ-024 While out_valid[o] && !out_ready[o], out_data[o] and out_valid[o] SHALL stay stable.
REQ-025 Latency SHALL be: flit accepted on edge k into an empty FIFO, uncontested, output loadable -> out_valid high after edge k+1.
REQ-026 Sustained throughput SHALL be one flit per cycle per output.
REQ-027 Loopback (destination == own input index) SHALL be legal.
REQ-028 FIFO order SHALL be preserved per input; flits from one input to one output SHALL never reorder.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or an occupancy counter.

Reset
REQ-030 On rst: all FIFOs empty; in_ready all 1 from the following cycle.
REQ-031 On rst: out_valid = 0, out_data = 0, drop_cnt = 0, and all arbiter pointers set so input 0 has highest priority.
REQ-032 rst asserted mid-traffic SHALL discard all buffered and output flits with no partial state retained.

Structure
REQ-033 Shared package router_pkg SHALL hold port index constants (LOCAL, EAST, WEST, NORTH, SOUTH) and the clog2 helper.
REQ-034 A sub-module rr_arbiter (parameter N; req, en, gnt one-hot, internal pointer) SHALL be instantiated once per output.
REQ-035 FIFO storage SHALL be inline per input.

Verification
REQ-036 Reset, then input 1 sends 8'h43 (dest 2) with out_ready all 1 -> out_valid[2] = 1 and out_data[2] = 8'h43 one cycle after acceptance; drop_cnt = 0.
REQ-037 Inputs 0, 1, 3 each send 4 flits to dest 4 simultaneously -> output 4 serves inputs in order 0, 1, 3, 0, 1, 3, ... over 12 consecutive cycles.
REQ-038 out_ready[2] = 0 while input 0 sends 6 flits to dest 2 (DEPTH = 4) -> in_ready[0] drops after 5 accepted flits (4 in FIFO, 1 in output register), out_data stable; release -> all 6 flits delivered in order.
REQ-039 With NPORTS = 5, input 3 sends destination 7 -> no out_valid asserted and drop_cnt = 1; 70000 such flits -> drop_cnt = 16'hFFFF.
REQ-040 rst asserted for 1 cycle with 3 flits buffered and out_valid[1] = 1 -> out_valid = 0, drop_cnt = 0, and no stale flit emitted afterwards.
REQ-041 NPORTS = 3, DW = 16, DEPTH = 8 random traffic against a scoreboard -> per-input/per-output ordering preserved and no loss or duplication.
